k16_io_arbiter: RTL and testbench

Two-master arbiter that shares the single K16 I/O register port (3-bit address, 16-bit write data, write enable, registered 16-bit read data) between the CPU (master 0) and the front-panel monitor (master 1). It serialises requests with round-robin fairness and drives the peripheral for exactly one cycle per transaction. It returns read data through a req/ack handshake and sits between the CPU/monitor and the I/O peripheral.

---
 rtl/k16_io_arbiter_pkg.sv | 24 ++
 rtl/k16_io_arbiter_if.sv | 55 +++++
 rtl/k16_io_arbiter_rr_pick.sv | 11 +
 rtl/k16_io_arbiter.sv | 163 ++++++++++++++++
 tb/tb_k16_io_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/k16_io_arbiter_pkg.sv
// Shared definitions for the K16 I/O arbiter: FSM state encoding, master
// indices and the K16 I/O register map.
package k16_io_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam logic MASTER_CPU     = 1'b0;
    localparam logic MASTER_MONITOR = 1'b1;

    localparam logic [2:0] ADDR_SWITCHES        = 3'd0;
    localparam logic [2:0] CTRL_SWITCHES        = 3'd1;
    localparam logic [2:0] ADDR_LEDS            = 3'd2;
    localparam logic [2:0] DATA_LEDS            = 3'd3;
    localparam logic [2:0] CMD_AND_REG_SWITCHES = 3'd4;
    localparam logic [2:0] COUNTER_HI           = 3'd5;
    localparam logic [2:0] COUNTER_LO           = 3'd6;
    localparam logic [2:0] SOUND_DIVISOR        = 3'd7;

endpackage

// File: rtl/k16_io_arbiter_if.sv
// Bundle of the two master request ports and the shared peripheral port.
// The m*_lock signals exist only when K16_IO_ARB_LOCK_EN is defined.
interface k16_io_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_din;
    logic              m0_we;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_dout;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_din;
    logic              m1_we;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_dout;

`ifdef K16_IO_ARB_LOCK_EN
    logic              m0_lock;
    logic              m1_lock;
`endif

    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_din;
    logic              per_write_en;
    logic [DATA_W-1:0] per_dout;

    // Arbiter side
    modport slave (
`ifdef K16_IO_ARB_LOCK_EN
        input  m0_lock, m1_lock,
`endif
        input  m0_req, m0_addr, m0_din, m0_we,
        input  m1_req, m1_addr, m1_din, m1_we,
        input  per_dout,
        output m0_ack, m0_dout, m1_ack, m1_dout,
        output per_addr, per_din, per_write_en
    );

    // Requesters plus peripheral side
    modport master (
`ifdef K16_IO_ARB_LOCK_EN
        output m0_lock, m1_lock,
`endif
        output m0_req, m0_addr, m0_din, m0_we,
        output m1_req, m1_addr, m1_din, m1_we,
        output per_dout,
        input  m0_ack, m0_dout, m1_ack, m1_dout,
        input  per_addr, per_din, per_write_en
    );

endinterface

// File: rtl/k16_io_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a tie goes to the master that was not granted last.
module k16_rr_pick (
    input  logic [1:0] reqs,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);
    assign valid = |reqs;
    assign grant = (&reqs) ? ~last_grant : reqs[1];
endmodule

// File: rtl/k16_io_arbiter.sv
// Two-master round-robin arbiter for the K16 I/O register port.
// Bus locking is compiled in when K16_IO_ARB_LOCK_EN is defined.
module k16_io_arbiter
    import k16_io_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic            clk,
    input  logic            reset,
    k16_io_arbiter_if.slave bus
);
    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] dout0_q;
    logic [DATA_W-1:0] dout1_q;
    logic [1:0]        eligible;
    logic              pick_valid;
    logic              pick_grant;
    logic              ack0;
    logic              ack1;
    logic              write_en;

    generate
        if (LOCK_MAX < 1) begin : g_bad_lock_max
            $error("LOCK_MAX must be at least 1");
        end
    endgenerate

`ifdef K16_IO_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic             lock_active;
    logic             lock_owner;
    logic             owner_lock;
    logic             grantee_lock;
    logic [CNT_W-1:0] lock_count;
    logic [CNT_W-1:0] count_next;

    assign owner_lock   = lock_owner ? bus.m1_lock : bus.m0_lock;
    assign grantee_lock = owner ? bus.m1_lock : bus.m0_lock;
    assign count_next   = lock_active ? lock_count + CNT_W'(1) : CNT_W'(1);

    // A held lock hides the other master from the picker entirely
    always_comb begin
        eligible = {bus.m1_req, bus.m0_req};
        if (lock_active && owner_lock)
            eligible = lock_owner ? {bus.m1_req, 1'b0} : {1'b0, bus.m0_req};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_owner  <= MASTER_CPU;
            lock_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lock_active && !owner_lock) begin
                        lock_active <= 1'b0;
                        lock_count  <= '0;
                    end
                end
                ST_ACK: begin
                    // Forced release needs no extra last_grant handling: the
                    // owner is the grantee here, so the other master wins next tie.
                    if (grantee_lock) begin
                        if (count_next >= CNT_W'(LOCK_MAX)) begin
                            lock_active <= 1'b0;
                            lock_count  <= '0;
                        end else begin
                            lock_active <= 1'b1;
                            lock_owner  <= owner;
                            lock_count  <= count_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign eligible = {bus.m1_req, bus.m0_req};
`endif

    k16_rr_pick u_pick (
        .reqs       (eligible),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        write_en   = 1'b0;
        case (state)
            ST_IDLE:    if (pick_valid) state_next = ST_ACCESS;
            ST_ACCESS: begin
                write_en   = we_q;
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: state_next = ST_ACK;
            ST_ACK: begin
                ack0       = (owner == MASTER_CPU);
                ack1       = (owner == MASTER_MONITOR);
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= MASTER_CPU;
            last_grant <= MASTER_MONITOR;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner  <= pick_grant;
                        addr_q <= pick_grant ? bus.m1_addr : bus.m0_addr;
                        din_q  <= pick_grant ? bus.m1_din  : bus.m0_din;
                        we_q   <= pick_grant ? bus.m1_we   : bus.m0_we;
                    end
                end
                // Peripheral read data lags the address by one cycle
                ST_CAPTURE: begin
                    if (owner == MASTER_MONITOR) dout1_q <= bus.per_dout;
                    else                         dout0_q <= bus.per_dout;
                end
                ST_ACK:     last_grant <= owner;
                default: ;
            endcase
        end
    end

    assign bus.m0_ack       = ack0;
    assign bus.m1_ack       = ack1;
    assign bus.m0_dout      = dout0_q;
    assign bus.m1_dout      = dout1_q;
    assign bus.per_addr     = addr_q;
    assign bus.per_din      = din_q;
    assign bus.per_write_en = write_en;

endmodule

// File: tb/tb_k16_io_arbiter.sv
// Directed bench for k16_io_arbiter: per-cycle vector table plus reset and
// lock sequences (lock sequences only when K16_IO_ARB_LOCK_EN is defined).
module tb_k16_io_arbiter;
    import k16_io_arbiter_pkg::*;

    typedef struct {
        logic        m0_req;
        logic [2:0]  m0_addr;
        logic [15:0] m0_din;
        logic        m0_we;
        logic        m1_req;
        logic [2:0]  m1_addr;
        logic [15:0] m1_din;
        logic        m1_we;
        logic        ack0;
        logic        ack1;
        logic [15:0] dout0;
        logic [15:0] dout1;
        logic        pwe;
        logic [2:0]  paddr;
        logic [15:0] pdin;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        per_init;
    logic [15:0] regs [8];
    vec_t        vecs [$];
    int          checks = 0;
    int          errors = 0;
    int          nack;
    int          order [16];
    int          ack_cyc [16];

    k16_io_arbiter_if bus ();

    k16_io_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Peripheral: registered read of the current address, read-before-write
    always @(posedge clk) begin
        if (per_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
            regs[ADDR_LEDS]  <= 16'h0F0F;
            regs[DATA_LEDS]  <= 16'hA5A5;
            regs[COUNTER_LO] <= 16'h1234;
            bus.per_dout     <= 16'h0000;
        end else begin
            if (bus.per_write_en) regs[bus.per_addr] <= bus.per_din;
            bus.per_dout <= regs[bus.per_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic m0r, input logic [2:0] m0a, input logic [15:0] m0d, input logic m0w,
        input logic m1r, input logic [2:0] m1a, input logic [15:0] m1d, input logic m1w,
        input logic a0, input logic a1, input logic [15:0] d0, input logic [15:0] d1,
        input logic pwe, input logic [2:0] pa, input logic [15:0] pd);
        vec_t v;
        v.m0_req = m0r; v.m0_addr = m0a; v.m0_din = m0d; v.m0_we = m0w;
        v.m1_req = m1r; v.m1_addr = m1a; v.m1_din = m1d; v.m1_we = m1w;
        v.ack0 = a0; v.ack1 = a1; v.dout0 = d0; v.dout1 = d1;
        v.pwe = pwe; v.paddr = pa; v.pdin = pd;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_din = '0; bus.m0_we = 1'b0;
        bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_din = '0; bus.m1_we = 1'b0;
`ifdef K16_IO_ARB_LOCK_EN
        bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
`endif
    endtask

    // Leaves the bench at posedge+1 with the DUT in its first IDLE cycle
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic collect_acks(input int max_cyc, input int want, input int drop_lock_cyc);
        nack = 0;
        for (int c = 0; c < max_cyc && nack < want; c++) begin
            if (c == 1) begin
                bus.m0_req = 1'b1;
            end
`ifdef K16_IO_ARB_LOCK_EN
            if (c == drop_lock_cyc) bus.m0_lock = 1'b0;
`endif
            @(negedge clk);
            if (bus.m0_ack && nack < 16) begin order[nack] = 0; ack_cyc[nack] = c; nack++; end
            if (bus.m1_ack && nack < 16) begin order[nack] = 1; ack_cyc[nack] = c; nack++; end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clear_inputs();
        reset    = 1'b1;
        per_init = 1'b1;
        @(posedge clk);
        #1 per_init = 1'b0;
        @(negedge clk);
        chk("rst_ack0",  32'(bus.m0_ack), 32'h0);
        chk("rst_ack1",  32'(bus.m1_ack), 32'h0);
        chk("rst_dout0", 32'(bus.m0_dout), 32'h0);
        chk("rst_dout1", 32'(bus.m1_dout), 32'h0);
        chk("rst_pwe",   32'(bus.per_write_en), 32'h0);
        chk("rst_paddr", 32'(bus.per_addr), 32'h0);
        chk("rst_pdin",  32'(bus.per_din), 32'h0);

        // m0 read alone, m1 write then read-back, then sustained contention
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, COUNTER_LO, 0, 0, 0, 0, 0, 0,
                              (i == 3), 0, (i == 3) ? 16'h1234 : 16'h0, 0, 0, (i == 0) ? 3'd0 : 3'd6, 0));
        vecs.push_back(mk(0, COUNTER_LO, 0, 0, 0, 0, 0, 0,         0, 0, 16'h1234, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 16'h00FF, 1, 0, 0, 16'h1234, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 16'h00FF, 1, 0, 0, 16'h1234, 0, 1, 7, 16'h00FF));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 16'h00FF, 1, 0, 0, 16'h1234, 0, 0, 7, 16'h00FF));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 16'h00FF, 1, 0, 1, 16'h1234, 0, 0, 7, 16'h00FF));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 0, 0,      0, 0, 16'h1234, 0, 0, 7, 16'h00FF));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 0, 0,      0, 0, 16'h1234, 0, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 0, 0,      0, 0, 16'h1234, 0, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, SOUND_DIVISOR, 0, 0,      0, 1, 16'h1234, 16'h00FF, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, SOUND_DIVISOR, 0, 0,      0, 0, 16'h1234, 16'h00FF, 0, 7, 0));
        for (int i = 14; i < 28; i++) begin
            logic        a0, a1;
            logic [15:0] d0, d1, pd;
            logic [2:0]  pa;
            a0 = (i == 17) || (i == 25);
            a1 = (i == 21);
            d0 = (i >= 17) ? 16'hA5A5 : 16'h1234;
            d1 = (i >= 21) ? 16'h1234 : 16'h00FF;
            pa = (i == 14) ? 3'd7 : ((i >= 19 && i <= 22) ? 3'd6 : 3'd3);
            pd = (i == 14) ? 16'h0 : ((i >= 19 && i <= 22) ? 16'h2222 : 16'h1111);
            vecs.push_back(mk((i < 26), DATA_LEDS, 16'h1111, 0, (i < 26), COUNTER_LO, 16'h2222, 0,
                              a0, a1, d0, d1, 0, pa, pd));
        end

        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.m0_req = vecs[i].m0_req; bus.m0_addr = vecs[i].m0_addr;
            bus.m0_din = vecs[i].m0_din; bus.m0_we   = vecs[i].m0_we;
            bus.m1_req = vecs[i].m1_req; bus.m1_addr = vecs[i].m1_addr;
            bus.m1_din = vecs[i].m1_din; bus.m1_we   = vecs[i].m1_we;
            @(negedge clk);
            chk($sformatf("c%0d_ack0", i),  32'(bus.m0_ack),       32'(vecs[i].ack0));
            chk($sformatf("c%0d_ack1", i),  32'(bus.m1_ack),       32'(vecs[i].ack1));
            chk($sformatf("c%0d_dout0", i), 32'(bus.m0_dout),      32'(vecs[i].dout0));
            chk($sformatf("c%0d_dout1", i), 32'(bus.m1_dout),      32'(vecs[i].dout1));
            chk($sformatf("c%0d_pwe", i),   32'(bus.per_write_en), 32'(vecs[i].pwe));
            chk($sformatf("c%0d_paddr", i), 32'(bus.per_addr),     32'(vecs[i].paddr));
            chk($sformatf("c%0d_pdin", i),  32'(bus.per_din),      32'(vecs[i].pdin));
            @(posedge clk);
            #1;
        end
        chk("sound_divisor_reg", 32'(regs[SOUND_DIVISOR]), 32'h00FF);

        // Reset asserted in the middle of a write's ACCESS cycle
        bus.m0_req = 1'b1; bus.m0_addr = ADDR_LEDS; bus.m0_din = 16'hBEEF; bus.m0_we = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_pwe_before", 32'(bus.per_write_en), 32'h1);
        chk("mid_paddr",      32'(bus.per_addr),     32'(ADDR_LEDS));
        #1 reset = 1'b1;
        #1;
        chk("mid_pwe_async",  32'(bus.per_write_en), 32'h0);
        chk("mid_ack0",       32'(bus.m0_ack),       32'h0);
        chk("mid_dout0",      32'(bus.m0_dout),      32'h0);
        chk("mid_dout1",      32'(bus.m1_dout),      32'h0);
        bus.m0_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_reg_unchanged", 32'(regs[ADDR_LEDS]), 32'h0F0F);
        reset = 1'b0;
        bus.m0_req = 1'b1; bus.m0_addr = COUNTER_LO; bus.m0_din = 0; bus.m0_we = 1'b0;
        bus.m1_req = 1'b1; bus.m1_addr = DATA_LEDS;  bus.m1_din = 0; bus.m1_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_c%0d_ack0", c), 32'(bus.m0_ack), 32'(c == 3));
            chk($sformatf("post_rst_c%0d_ack1", c), 32'(bus.m1_ack), 32'h0);
            @(posedge clk);
            #1;
        end
        chk("post_rst_dout0", 32'(bus.m0_dout), 32'h1234);

`ifdef K16_IO_ARB_LOCK_EN
        // m1 holds lock with back-to-back reads; m0 joins one cycle later
        do_reset();
        bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_addr = ADDR_SWITCHES;
        bus.m0_addr = CTRL_SWITCHES;
        collect_acks(60, 9, -1);
        chk("lockA_nack", 32'(nack), 32'd9);
        for (int k = 0; k < 9 && k < nack; k++)
            chk($sformatf("lockA_ack%0d_owner", k), 32'(order[k]), 32'(k < 8 ? 1 : 0));

        // m0 locks for two transactions, then drops lock with m1 waiting
        do_reset();
        bus.m0_req = 1'b1; bus.m0_lock = 1'b1; bus.m0_addr = ADDR_SWITCHES;
        bus.m1_req = 1'b1; bus.m1_addr = CTRL_SWITCHES;
        collect_acks(20, 3, 8);
        chk("lockB_nack", 32'(nack), 32'd3);
        for (int k = 0; k < 3 && k < nack; k++) begin
            chk($sformatf("lockB_ack%0d_owner", k), 32'(order[k]),   32'(k == 2 ? 1 : 0));
            chk($sformatf("lockB_ack%0d_cycle", k), 32'(ack_cyc[k]), 32'(3 + 4 * k));
        end
        clear_inputs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
